fetch_decode_latch: RTL and testbench



---
 rtl/fetch_decode_latch_pkg.sv | 14 +
 rtl/fetch_decode_latch_if.sv | 27 ++
 rtl/fetch_decode_latch_stall_counter.sv | 29 ++
 rtl/fetch_decode_latch.sv | 111 +++++++++++
 tb/tb_fetch_decode_latch.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/fetch_decode_latch_pkg.sv
// Shared definitions for the fetch stage: PC width, NOP encoding and fetch FSM states.
package fetch_decode_latch_pkg;

  localparam int unsigned PC_W = 16;
  localparam int unsigned CNT_W = 3;
  localparam logic [PC_W-1:0] NOP_INSTR_DEF = 16'h0800;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_decode_latch_if.sv
// Fetch/decode boundary bus: hazard/redirect inputs in, PC and IF/ID latch out.
interface fetch_decode_latch_if;
  import fetch_decode_latch_pkg::*;

  logic            insert_nop;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            halt_dec;
  logic [PC_W-1:0] instr_in;
  logic [PC_W-1:0] pc_out;
  logic [PC_W-1:0] if_id_instr;
  logic [PC_W-1:0] if_id_pc_plus2;
  logic            if_id_valid;
  logic            id_ex_bubble;
  logic            halted;

  modport master (
    output insert_nop, br_taken, br_target, halt_dec, instr_in,
    input  pc_out, if_id_instr, if_id_pc_plus2, if_id_valid, id_ex_bubble, halted
  );

  modport slave (
    input  insert_nop, br_taken, br_target, halt_dec, instr_in,
    output pc_out, if_id_instr, if_id_pc_plus2, if_id_valid, id_ex_bubble, halted
  );

endinterface

// File: rtl/fetch_decode_latch_stall_counter.sv
// 3-bit loadable down-counter that sequences the fetch stall; saturates at zero.
module stall_counter
  import fetch_decode_latch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign count = cnt;
  assign zero  = (cnt == '0);

endmodule

// File: rtl/fetch_decode_latch.sv
// Fetch PC register and IF/ID latch with hazard stall stretching, redirect flush and HALT freeze.
module fetch_decode_latch
  import fetch_decode_latch_pkg::*;
#(
  parameter int unsigned     STALL_CYCLES = 3,
  parameter logic [PC_W-1:0] RESET_PC     = 16'h0000,
  parameter logic [PC_W-1:0] NOP_INSTR    = NOP_INSTR_DEF
) (
  input logic                 clk,
  input logic                 rst,
  fetch_decode_latch_if.slave bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STALL_CYCLES - 1);

  fetch_state_e     state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_plus2;
  logic [PC_W-1:0]  ifid_instr;
  logic [PC_W-1:0]  ifid_pc2;
  logic             ifid_valid;
  logic             halted_q;
  logic             bubble;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             stall_done;

  assign pc_plus2 = pc + PC_W'(2);
  // STALL lasts STALL_CYCLES-1 cycles after the pulse cycle, so leave when the count is about to hit zero.
  assign stall_done = cnt_zero || (cnt == CNT_W'(1));

  always_comb begin
    bubble   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = RELOAD;
    if (state != ST_HALT) begin
      if (bus.halt_dec || bus.br_taken) begin
        cnt_load = 1'b1;
        cnt_val  = '0;
      end else if (bus.insert_nop) begin
        bubble   = 1'b1;
        cnt_load = 1'b1;
      end else if (state == ST_STALL) begin
        bubble  = 1'b1;
        cnt_dec = 1'b1;
      end
    end
  end

  stall_counter u_stall_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_pc2   <= '0;
      ifid_valid <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state)
        ST_RUN, ST_STALL: begin
          if (bus.halt_dec) begin
            state      <= ST_HALT;
            halted_q   <= 1'b1;
            ifid_instr <= NOP_INSTR;
            ifid_pc2   <= '0;
            ifid_valid <= 1'b0;
          end else if (bus.br_taken) begin
            state      <= ST_RUN;
            pc         <= bus.br_target;
            ifid_instr <= NOP_INSTR;
            ifid_pc2   <= '0;
            ifid_valid <= 1'b0;
          end else if (bus.insert_nop) begin
            state <= (STALL_CYCLES > 1) ? ST_STALL : ST_RUN;
          end else if (state == ST_STALL) begin
            if (stall_done) state <= ST_RUN;
          end else begin
            pc         <= pc_plus2;
            ifid_instr <= bus.instr_in;
            ifid_pc2   <= pc_plus2;
            ifid_valid <= 1'b1;
          end
        end
        ST_HALT: ;
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc_out         = pc;
  assign bus.if_id_instr    = ifid_instr;
  assign bus.if_id_pc_plus2 = ifid_pc2;
  assign bus.if_id_valid    = ifid_valid;
  assign bus.id_ex_bubble   = bubble;
  assign bus.halted         = halted_q;

endmodule

// File: tb/tb_fetch_decode_latch.sv
// Directed vectors for fetch_decode_latch; expectations queued per cycle, checked by a separate monitor.
module tb_fetch_decode_latch;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
    logic [15:0] p2;
    logic        v;
    logic        bub;
    logic        hlt;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   checks;
  int   errors;

  fetch_decode_latch_if bus ();

  fetch_decode_latch #(
    .STALL_CYCLES (3),
    .RESET_PC     (16'h0000),
    .NOP_INSTR    (16'h0800)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_out",         bus.pc_out,                 e.pc);
        chk("if_id_instr",    bus.if_id_instr,            e.ins);
        chk("if_id_pc_plus2", bus.if_id_pc_plus2,         e.p2);
        chk("if_id_valid",    {15'd0, bus.if_id_valid},   {15'd0, e.v});
        chk("id_ex_bubble",   {15'd0, bus.id_ex_bubble},  {15'd0, e.bub});
        chk("halted",         {15'd0, bus.halted},        {15'd0, e.hlt});
      end
    end
  end

  task automatic push(input logic [15:0] pc, ins, p2, input logic v, bub, hlt);
    exp_t e;
    e.pc = pc; e.ins = ins; e.p2 = p2; e.v = v; e.bub = bub; e.hlt = hlt;
    q.push_back(e);
  endtask

  task automatic drive(input logic nop, br, input logic [15:0] tgt, input logic hlt_in,
                       input logic [15:0] instr);
    bus.insert_nop = nop;
    bus.br_taken   = br;
    bus.br_target  = tgt;
    bus.halt_dec   = hlt_in;
    bus.instr_in   = instr;
  endtask

  task automatic step(input logic nop, br, input logic [15:0] tgt, input logic hlt_in,
                      input logic [15:0] instr,
                      input logic [15:0] e_pc, e_ins, e_p2, input logic e_v, e_bub, e_hlt);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(nop, br, tgt, hlt_in, instr);
    push(e_pc, e_ins, e_p2, e_v, e_bub, e_hlt);
  endtask

  task automatic reset_step();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    push(16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int budget;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    reset_step();
    //    nop br  target  halt instr     pc       ins      p2       v  bub hlt
    step(0, 0, 16'h0000, 0, 16'h1111, 16'h0000, 16'h0800, 16'h0000, 0, 0, 0);
    step(0, 0, 16'h0000, 0, 16'h2222, 16'h0002, 16'h1111, 16'h0002, 1, 0, 0);
    step(1, 0, 16'h0000, 0, 16'h3333, 16'h0004, 16'h2222, 16'h0004, 1, 1, 0);
    step(0, 0, 16'h0000, 0, 16'h3333, 16'h0004, 16'h2222, 16'h0004, 1, 1, 0);
    step(0, 0, 16'h0000, 0, 16'h3333, 16'h0004, 16'h2222, 16'h0004, 1, 1, 0);
    step(0, 0, 16'h0000, 0, 16'h3333, 16'h0004, 16'h2222, 16'h0004, 1, 0, 0);
    // stall then redirect mid-stall
    step(1, 0, 16'h0000, 0, 16'h4444, 16'h0006, 16'h3333, 16'h0006, 1, 1, 0);
    step(0, 1, 16'h0040, 0, 16'h4444, 16'h0006, 16'h3333, 16'h0006, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 16'h5555, 16'h0040, 16'h0800, 16'h0000, 0, 0, 0);
    // branch and insert_nop together: redirect only
    step(1, 1, 16'h0100, 0, 16'h5a5a, 16'h0042, 16'h5555, 16'h0042, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 16'h6666, 16'h0100, 16'h0800, 16'h0000, 0, 0, 0);
    step(0, 0, 16'h0000, 0, 16'h7777, 16'h0102, 16'h6666, 16'h0102, 1, 0, 0);
    // reload while stalled: no accumulation, restart of the count
    step(1, 0, 16'h0000, 0, 16'h8888, 16'h0104, 16'h7777, 16'h0104, 1, 1, 0);
    step(0, 0, 16'h0000, 0, 16'h8888, 16'h0104, 16'h7777, 16'h0104, 1, 1, 0);
    step(1, 0, 16'h0000, 0, 16'h8888, 16'h0104, 16'h7777, 16'h0104, 1, 1, 0);
    step(0, 0, 16'h0000, 0, 16'h8888, 16'h0104, 16'h7777, 16'h0104, 1, 1, 0);
    step(0, 0, 16'h0000, 0, 16'h8888, 16'h0104, 16'h7777, 16'h0104, 1, 1, 0);
    step(0, 0, 16'h0000, 0, 16'h8888, 16'h0104, 16'h7777, 16'h0104, 1, 0, 0);
    step(0, 1, 16'h000e, 0, 16'h1234, 16'h0106, 16'h8888, 16'h0106, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 16'h9999, 16'h000e, 16'h0800, 16'h0000, 0, 0, 0);
    // halt beats branch and insert_nop; everything ignored afterwards
    step(1, 1, 16'h0200, 1, 16'habcd, 16'h0010, 16'h9999, 16'h0010, 1, 0, 0);
    step(1, 0, 16'h0000, 0, 16'hbeef, 16'h0010, 16'h0800, 16'h0000, 0, 0, 1);
    step(0, 1, 16'h0300, 0, 16'hcafe, 16'h0010, 16'h0800, 16'h0000, 0, 0, 1);
    step(1, 1, 16'h0400, 1, 16'hf00d, 16'h0010, 16'h0800, 16'h0000, 0, 0, 1);
    step(0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 16'h0800, 16'h0000, 0, 0, 1);
    reset_step();
    step(0, 0, 16'h0000, 0, 16'h1111, 16'h0000, 16'h0800, 16'h0000, 0, 0, 0);
    // reset mid-stall leaves no residual bubble
    step(1, 0, 16'h0000, 0, 16'h2222, 16'h0002, 16'h1111, 16'h0002, 1, 1, 0);
    reset_step();
    step(0, 0, 16'h0000, 0, 16'haaaa, 16'h0000, 16'h0800, 16'h0000, 0, 0, 0);
    // PC wrap at the top of the address space
    step(0, 1, 16'hfffe, 0, 16'h2468, 16'h0002, 16'haaaa, 16'h0002, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 16'hbbbb, 16'hfffe, 16'h0800, 16'h0000, 0, 0, 0);
    step(0, 0, 16'h0000, 0, 16'hcccc, 16'h0000, 16'hbbbb, 16'h0000, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 16'hdddd, 16'h0002, 16'hcccc, 16'h0002, 1, 0, 0);

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
